// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction loader and its storage.
// Holds the loader FSM state encoding, the instruction width and the default depth.
package cpu_pkg;

  localparam int INSTR_W       = 32;
  localparam int DEFAULT_DEPTH = 256;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/imem.sv
// Instruction storage: DEPTH x 32 words, one write port, one registered read port.
// Read data appears one cycle after the address; contents are never reset.
module imem
  import cpu_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_loader.sv
// Streams a program into imem via valid/ready, then releases the CPU; INSTR_LOADER_CHECKSUM_EN adds an XOR check on the last beat.
// Fetch latency 1 cycle (pc -> ins_out); ld_ready is high only in IDLE/LOAD, so a stalled ld_valid simply holds state.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_last,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ins_out,
  output logic               cpu_set,
  output logic [ADDR_W-1:0]  end_addr,
  output logic               loaded,
  output logic               err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  loader_state_t      r_state;
  loader_state_t      w_state_nxt;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  w_ptr_nxt;
  logic [ADDR_W-1:0]  r_end_addr;
  logic [ADDR_W-1:0]  w_end_nxt;
  logic               r_rst_done;
  logic               r_rd_ok;
  logic               w_accept;
  logic               w_full;
  logic               w_we;
  logic [INSTR_W-1:0] w_rd_data;

  assign w_accept = ld_valid & ld_ready;
  assign w_full   = (r_wr_ptr == LAST_IDX);

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] r_csum;
  logic               w_csum_ok;

  assign w_csum_ok = (r_csum == ld_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum <= NOP_WORD;
    end else if (w_we) begin
      r_csum <= r_csum ^ ld_data;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_wr_ptr;
    w_end_nxt   = r_end_addr;
    w_we        = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          // The last beat is the checksum, so the final stored word sits one below wr_ptr.
          if (ld_last) begin
            if (r_state == ST_LOAD && w_csum_ok) begin
              w_state_nxt = ST_READY;
              w_end_nxt   = r_wr_ptr - ADDR_W'(1);
            end else begin
              w_state_nxt = ST_ERR;
            end
          end else begin
            w_we = 1'b1;
            if (w_full) begin
              w_state_nxt = ST_READY;
              w_end_nxt   = r_wr_ptr;
            end else begin
              w_state_nxt = ST_LOAD;
              w_ptr_nxt   = r_wr_ptr + ADDR_W'(1);
            end
          end
`else
          w_we = 1'b1;
          if (ld_last || w_full) begin
            w_state_nxt = ST_READY;
            w_end_nxt   = r_wr_ptr;
          end else begin
            w_state_nxt = ST_LOAD;
            w_ptr_nxt   = r_wr_ptr + ADDR_W'(1);
          end
`endif
        end
      end
      ST_READY: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_end_addr <= '0;
      r_rst_done <= 1'b0;
      r_rd_ok    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_ptr_nxt;
      r_end_addr <= w_end_nxt;
      r_rst_done <= 1'b1;
      r_rd_ok    <= (r_state == ST_RUN) && (pc <= r_end_addr);
    end
  end

  imem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (ld_data),
    .i_raddr (pc),
    .o_rdata (w_rd_data)
  );

  // r_rd_ok clears asynchronously, which forces ins_out to NOP during reset.
  assign ins_out  = r_rd_ok ? w_rd_data : NOP_WORD;
  assign ld_ready = r_rst_done && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
  assign cpu_set  = (r_state == ST_RUN);
  assign loaded   = (r_state == ST_READY) || (r_state == ST_RUN);
  assign end_addr = r_end_addr;

`ifdef INSTR_LOADER_CHECKSUM_EN
  assign err = (r_state == ST_ERR);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader; checksum scenarios build only with INSTR_LOADER_CHECKSUM_EN.
module tb_instr_loader;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        start;
  logic [7:0]  pc;
  logic [31:0] ins_out;
  logic        cpu_set;
  logic [7:0]  end_addr;
  logic        loaded;
  logic        err;

  int total = 0;
  int bad   = 0;

  instr_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .start    (start),
    .pc       (pc),
    .ins_out  (ins_out),
    .cpu_set  (cpu_set),
    .end_addr (end_addr),
    .loaded   (loaded),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic read_pc(input logic [7:0] a);
    pc = a;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst      = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    start    = 1'b0;
    pc       = '0;

    #2;
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_loaded",   {31'd0, loaded},   32'd0);
    chk("rst_cpu_set",  {31'd0, cpu_set},  32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);
    chk("rst_end_addr", {24'd0, end_addr}, 32'd0);
    chk("rst_ins_out",  ins_out,           32'd0);

    tick();
    rst = 1'b1;
    chk("ld_ready_before_edge", {31'd0, ld_ready}, 32'd0);
    tick();
    chk("ld_ready_after_release", {31'd0, ld_ready}, 32'd1);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Checksum pass: 1 ^ 2 == 3
    beat(32'h1, 1'b0);
    beat(32'h2, 1'b0);
    beat(32'h3, 1'b1);
    chk("cs_pass_loaded",   {31'd0, loaded},   32'd1);
    chk("cs_pass_end_addr", {24'd0, end_addr}, 32'd1);
    chk("cs_pass_err",      {31'd0, err},      32'd0);
    pulse_start();
    chk("cs_pass_cpu_set",  {31'd0, cpu_set},  32'd1);
    read_pc(8'd1);
    chk("cs_pass_pc1",      ins_out,           32'h2);
    read_pc(8'd2);
    chk("cs_pass_pc2_oor",  ins_out,           32'h0);

    // Checksum fail: 1 ^ 2 != 4
    pc = 8'd0;
    do_reset();
    beat(32'h1, 1'b0);
    beat(32'h2, 1'b0);
    beat(32'h4, 1'b1);
    chk("cs_fail_err",      {31'd0, err},      32'd1);
    chk("cs_fail_loaded",   {31'd0, loaded},   32'd0);
    chk("cs_fail_ld_ready", {31'd0, ld_ready}, 32'd0);
    pulse_start();
    tick();
    chk("cs_fail_cpu_set",  {31'd0, cpu_set},  32'd0);
    chk("cs_fail_err_hold", {31'd0, err},      32'd1);

    // Single-beat program is an error
    do_reset();
    beat(32'h0, 1'b1);
    chk("cs_single_err",    {31'd0, err},      32'd1);
`else
    // Basic load
    beat(32'h0050_0093, 1'b0);
    beat(32'h00A0_0113, 1'b0);
    beat(32'h0020_81B3, 1'b1);
    chk("basic_loaded",    {31'd0, loaded},   32'd1);
    chk("basic_end_addr",  {24'd0, end_addr}, 32'd2);
    chk("basic_ld_ready",  {31'd0, ld_ready}, 32'd0);
    chk("basic_cpu_set0",  {31'd0, cpu_set},  32'd0);
    chk("basic_err",       {31'd0, err},      32'd0);
    tick();
    chk("basic_ins_ready", ins_out,           32'd0);
    pulse_start();
    chk("basic_cpu_set1",  {31'd0, cpu_set},  32'd1);
    read_pc(8'd1);
    chk("basic_pc1",       ins_out,           32'h00A0_0113);
    read_pc(8'd0);
    chk("basic_pc0",       ins_out,           32'h0050_0093);
    read_pc(8'd2);
    chk("basic_pc2",       ins_out,           32'h0020_81B3);
    read_pc(8'd5);
    chk("basic_pc5_oor",   ins_out,           32'h0);
    read_pc(8'd3);
    chk("basic_pc3_oor",   ins_out,           32'h0);

    // Start during LOAD, ld_valid gaps, reset mid-load
    pc = 8'd0;
    do_reset();
    beat(32'h1111_1111, 1'b0);
    pulse_start();
    chk("bp_cpu_set_load", {31'd0, cpu_set},  32'd0);
    chk("bp_loaded_load",  {31'd0, loaded},   32'd0);
    chk("bp_ready_load",   {31'd0, ld_ready}, 32'd1);
    tick();
    tick();
    beat(32'h2222_2222, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("midrst_loaded",   {31'd0, loaded},   32'd0);
    tick();
    rst = 1'b1;
    tick();
    beat(32'hAAAA_0001, 1'b0);
    tick();
    tick();
    beat(32'hAAAA_0002, 1'b0);
    tick();
    start = 1'b1;
    beat(32'hAAAA_0003, 1'b1);
    start = 1'b0;
    chk("reload_cpu_set0", {31'd0, cpu_set},  32'd0);
    chk("reload_loaded",   {31'd0, loaded},   32'd1);
    chk("reload_end_addr", {24'd0, end_addr}, 32'd2);
    pulse_start();
    chk("reload_cpu_set1", {31'd0, cpu_set},  32'd1);
    read_pc(8'd0);
    chk("reload_pc0",      ins_out,           32'hAAAA_0001);
    read_pc(8'd1);
    chk("reload_pc1",      ins_out,           32'hAAAA_0002);
    read_pc(8'd2);
    chk("reload_pc2",      ins_out,           32'hAAAA_0003);
`endif

    // Overflow: 256 beats with no ld_last
    pc = 8'd0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      beat(32'h1000_0000 + 32'(i), 1'b0);
    end
    chk("ovf_loaded",      {31'd0, loaded},   32'd1);
    chk("ovf_end_addr",    {24'd0, end_addr}, 32'd255);
    chk("ovf_ld_ready",    {31'd0, ld_ready}, 32'd0);
    beat(32'hDEAD_BEEF, 1'b0);
    chk("ovf_extra_end",   {24'd0, end_addr}, 32'd255);
    chk("ovf_extra_ready", {31'd0, ld_ready}, 32'd0);
    pulse_start();
    chk("ovf_cpu_set",     {31'd0, cpu_set},  32'd1);
    read_pc(8'd255);
    chk("ovf_pc255",       ins_out,           32'h1000_00FF);
    read_pc(8'd0);
    chk("ovf_pc0",         ins_out,           32'h1000_0000);
    read_pc(8'd128);
    chk("ovf_pc128",       ins_out,           32'h1000_0080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit instruction words held.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning the width of the pc and address fields (log2 DEPTH).
REQ-003 The block SHALL have port clk  input  1  meaning the single system clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port ld_valid  input  1  meaning the load beat is valid.
REQ-006 The block SHALL have port ld_ready  output  1  meaning the block accepts a load beat this cycle.
REQ-007 The block SHALL have port ld_data  input  32  meaning the instruction word, or the checksum on the last beat when CHECKSUM is compiled in.
REQ-008 The block SHALL have port ld_last  input  1  meaning the final beat of the program.
REQ-009 The block SHALL have port start  input  1  meaning a request to release the CPU.
REQ-010 The block SHALL have port pc  input  ADDR_W  meaning the CPU program counter (word index).
REQ-011 The block SHALL have port ins_out  output  32  meaning the instruction word for the CPU ins_in port.
REQ-012 The block SHALL have port cpu_set  output  1  meaning the CPU is released to run.
REQ-013 The block SHALL have port end_addr  output  ADDR_W  meaning the index of the last stored instruction.
REQ-014 The block SHALL have port loaded  output  1  meaning the program is stored and the block is in state READY or RUN.
REQ-015 The block SHALL have port err  output  1  meaning a checksum mismatch occurred.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, READY, RUN and ERR.
REQ-017 The handshake SHALL be defined as follows: a beat is accepted when ld_valid and ld_ready are both high, and ld_ready SHALL be 1 only in IDLE and LOAD.
REQ-018 In IDLE, the first accepted beat SHALL be written to mem[0], set wr_ptr to 1, and move the FSM to LOAD, or to READY if ld_last is high.
REQ-019 In LOAD, each accepted beat SHALL write mem[wr_ptr] and increment wr_ptr.
REQ-020 When a beat with ld_last high is accepted, the FSM SHALL go to READY and set end_addr to the index of the last stored word.
REQ-021 If a beat is accepted at wr_ptr = DEPTH-1 without ld_last, it SHALL be treated as last: the FSM goes to READY, end_addr = DEPTH-1, and wr_ptr does not wrap.
REQ-022 In READY, start high SHALL move the FSM to RUN, with cpu_set = 1 from the next cycle.
REQ-023 In every state other than READY, start SHALL be ignored.
REQ-024 In RUN, the read SHALL be registered with 1-cycle latency: ins_out = mem[pc] when pc <= end_addr, otherwise 32'h0000_0000.
REQ-025 RUN SHALL be left only by reset.
REQ-026 Outside RUN, ins_out SHALL be 0.
REQ-027 ld_valid and start asserted in the same cycle SHALL result in handling the beat only, since the FSM is not yet in READY.
REQ-028 An ld_valid that drops mid-program SHALL stall the load with no state change.

Reset
REQ-029 When rst is low, the block SHALL asynchronously force the FSM to IDLE, wr_ptr=0, end_addr=0, ins_out=0, cpu_set=0, loaded=0, err=0 and ld_ready=0.
REQ-030 ld_ready SHALL rise in the first cycle after rst deasserts.
REQ-031 The memory contents SHALL NOT be reset, and a reset mid-load SHALL discard the partial program.

Configuration
REQ-032 With the macro INSTR_LOADER_CHECKSUM_EN defined, the ld_last beat SHALL carry a checksum that is not stored, and end_addr SHALL equal the index of the last stored word.
REQ-033 With INSTR_LOADER_CHECKSUM_EN defined, a running XOR of all stored words SHALL be compared against that checksum: on a match the FSM goes to READY, on a mismatch it goes to ERR with err=1 and loaded=0.
REQ-034 With INSTR_LOADER_CHECKSUM_EN defined, ERR SHALL be left only by reset.
REQ-035 With INSTR_LOADER_CHECKSUM_EN defined, a single-beat program (ld_last on the first beat) SHALL go to ERR.
REQ-036 Without INSTR_LOADER_CHECKSUM_EN, the ld_last beat SHALL be stored as an instruction, err SHALL be tied to 0, and ERR SHALL be unreachable.

Structure
REQ-037 Package cpu_pkg SHALL hold the loader_state_t enum, INSTR_W=32, the default DEPTH, and the NOP_WORD constant (32'h0).
REQ-038 The storage SHALL be a sub-module imem (DEPTH x 32, one write port, one registered read port), instantiated once.

Verification
REQ-039 The bench SHALL cover a basic load (macro off): load 3 words 0x00500093, 0x00A00113, 0x002081B3 with last on the third, then pulse start; required response: loaded=1, end_addr=2, cpu_set=1 one cycle after start, and ins_out=0x00A00113 one cycle after pc=1.
REQ-040 The bench SHALL cover out-of-range pc: after the basic load, pc=5 -> ins_out=0 next cycle.
REQ-041 The bench SHALL cover overflow: 256 beats without ld_last -> READY, end_addr=255, ld_ready=0 from the next cycle; a 257th beat is not accepted.
REQ-042 The bench SHALL cover backpressure and start with reset mid-load: start pulsed during LOAD -> cpu_set stays 0; ld_valid gaps -> wr_ptr unchanged; rst low after 2 beats -> IDLE, loaded=0, and a reload from mem[0] succeeds.
REQ-043 The bench SHALL cover checksum pass (macro on): words 0x1, 0x2, then last beat 0x3 -> READY, end_addr=1, err=0.
REQ-044 The bench SHALL cover checksum fail (macro on): words 0x1, 0x2, then last beat 0x4 -> ERR, err=1, loaded=0; start is ignored and cpu_set stays 0.
